// File: rtl/bcd_display_scheduler.sv
// bcd_display_scheduler
//   Sequential front end for the shared 16-bit binary-to-BCD decoder in the
//   mouse position display path. Two requesters (X, Y) hand over 16-bit values
//   on valid/ready; a round-robin arbiter grants one, the operand is held for
//   SETTLE_CYCLES while the combinational decoder settles, and the five BCD
//   digits are stored in a per-channel buffer. A free-running scan counter
//   multiplexes the selected buffer onto a one-hot digit bus with leading-zero
//   blanking.
//
//   Optional feature macro: SIGN_DISPLAY_EN (two's-complement inputs, per
//   channel sign flags x_neg/y_neg, sixth display position for the minus sign).
//
//   Parameters:
//     SETTLE_CYCLES  decoder settle window before capture, 1..15
//     SCAN_DIV       clocks each digit position is held, >= 2
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     x_valid/x_value/x_ready  X requester handshake (x_ready combinational)
//     y_valid/y_value/y_ready  Y requester handshake (y_ready combinational)
//     disp_sel                 display channel select, 0 = X, 1 = Y
//     busy                     conversion in progress
//     done_pulse, done_ch      one-cycle buffer-updated strobe and its channel
//     x_digits, y_digits       {ten_thousands, thousands, hundreds, tens, units}
//     digit_en, digit_code     one-hot active position (bit 0 = units), BCD code
//                              (4'hF = blank, 4'hA = minus sign)
//     x_neg, y_neg             stored sign flags (SIGN_DISPLAY_EN only)

// Combinational 16-bit binary to 5-digit BCD (shift-and-add-3).
module bcd_decoder_16bit (
  input  logic [15:0] bin,
  output logic [19:0] bcd
);
  always_comb begin
    logic [35:0] sr;
    sr = {20'd0, bin};
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 5; d++) begin
        if (sr[16 + 4*d +: 4] >= 4'd5) begin
          sr[16 + 4*d +: 4] = sr[16 + 4*d +: 4] + 4'd3;
        end
      end
      sr = {sr[34:0], 1'b0};
    end
    bcd = sr[35:16];
  end
endmodule

module bcd_display_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SCAN_DIV      = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_valid,
  input  logic [15:0] x_value,
  output logic        x_ready,
  input  logic        y_valid,
  input  logic [15:0] y_value,
  output logic        y_ready,
  input  logic        disp_sel,
  output logic        busy,
  output logic        done_pulse,
  output logic        done_ch,
  output logic [19:0] x_digits,
  output logic [19:0] y_digits,
  output logic [3:0]  digit_code,
`ifdef SIGN_DISPLAY_EN
  output logic [5:0]  digit_en,
  output logic        x_neg,
  output logic        y_neg
`else
  output logic [4:0]  digit_en
`endif
);

`ifdef SIGN_DISPLAY_EN
  localparam int unsigned NPOS = 6;
`else
  localparam int unsigned NPOS = 5;
`endif
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, STORE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       operand_q, operand_d;
  logic              ch_q, ch_d;
  logic              last_q, last_d;          // channel served last, 1 = Y
  logic [19:0]       x_digits_q, x_digits_d;
  logic [19:0]       y_digits_q, y_digits_d;
  logic              done_pulse_q, done_pulse_d;
  logic              done_ch_q, done_ch_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [NPOS-1:0]   digit_en_q, digit_en_d;
  logic [3:0]        digit_code_q, digit_code_d;
`ifdef SIGN_DISPLAY_EN
  logic              sign_q, sign_d;
  logic              x_neg_q, x_neg_d;
  logic              y_neg_q, y_neg_d;
`endif

  logic        grant_x_c, grant_y_c, hs_c, settle_done_c;
  logic [15:0] val_in_c;
  logic [19:0] dec_bcd_c;
  logic [19:0] sel_digits_c;
  logic        sel_neg_c;
  logic [4:1]  blank_c;
  logic [3:0]  code_c;
  logic        wrap_c;

  // Shared decoder, fed only from the operand register.
  bcd_decoder_16bit u_dec (
    .bin (operand_q),
    .bcd (dec_bcd_c)
  );

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_x_c = 1'b0;
    grant_y_c = 1'b0;
    if (x_valid && y_valid) begin
      grant_x_c = last_q;
      grant_y_c = ~last_q;
    end else begin
      grant_x_c = x_valid;
      grant_y_c = y_valid;
    end
    hs_c          = (state_q == IDLE) && (grant_x_c || grant_y_c);
    settle_done_c = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    val_in_c      = grant_y_c ? y_value : x_value;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_c) state_d = SETTLE;
      SETTLE:  if (settle_done_c) state_d = STORE;
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ready is combinational on the requester valids.
  always_comb begin
    x_ready = 1'b0;
    y_ready = 1'b0;
    busy    = 1'b0;
    if (state_q == IDLE) begin
      x_ready = grant_x_c;
      y_ready = grant_y_c;
    end else begin
      busy = 1'b1;
    end
  end

  // Conversion datapath: operand latch, settle counter, buffer write.
  always_comb begin
    operand_d    = operand_q;
    ch_d         = ch_q;
    last_d       = last_q;
    cnt_d        = '0;
    x_digits_d   = x_digits_q;
    y_digits_d   = y_digits_q;
    done_pulse_d = 1'b0;
    done_ch_d    = done_ch_q;
`ifdef SIGN_DISPLAY_EN
    sign_d       = sign_q;
    x_neg_d      = x_neg_q;
    y_neg_d      = y_neg_q;
`endif
    if (hs_c) begin
`ifdef SIGN_DISPLAY_EN
      // 16'h8000 negates to itself, which reads as 32768 unsigned.
      operand_d = val_in_c[15] ? 16'(~val_in_c + 16'd1) : val_in_c;
      sign_d    = val_in_c[15];
`else
      operand_d = val_in_c;
`endif
      ch_d = grant_y_c;
    end
    if (state_q == SETTLE) cnt_d = cnt_q + CNT_W'(1);
    if (state_q == STORE) begin
      if (ch_q) y_digits_d = dec_bcd_c;
      else      x_digits_d = dec_bcd_c;
`ifdef SIGN_DISPLAY_EN
      if (ch_q) y_neg_d = sign_q;
      else      x_neg_d = sign_q;
`endif
      last_d       = ch_q;
      done_pulse_d = 1'b1;
      done_ch_d    = ch_q;
    end
  end

  // Leading-zero blanking of the selected buffer; units never blank.
  always_comb begin
    logic seen;
    seen         = 1'b0;
    blank_c      = '0;
    sel_digits_c = disp_sel ? y_digits_q : x_digits_q;
`ifdef SIGN_DISPLAY_EN
    sel_neg_c    = disp_sel ? y_neg_q : x_neg_q;
`else
    sel_neg_c    = 1'b0;
`endif
    for (int p = 4; p >= 1; p--) begin
      seen       = seen | (sel_digits_c[4*p +: 4] != 4'd0);
      blank_c[p] = ~seen;
    end
  end

  // Scan counter, index and registered digit bus.
  always_comb begin
    wrap_c       = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d   = wrap_c ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d        = idx_q;
    digit_en_d   = digit_en_q;
    digit_code_d = digit_code_q;
    code_c       = 4'hF;
    if (wrap_c) begin
      idx_d = (idx_q == 3'(NPOS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
    case (idx_d)
      3'd0:    code_c = sel_digits_c[3:0];
      3'd1:    code_c = blank_c[1] ? 4'hF : sel_digits_c[7:4];
      3'd2:    code_c = blank_c[2] ? 4'hF : sel_digits_c[11:8];
      3'd3:    code_c = blank_c[3] ? 4'hF : sel_digits_c[15:12];
      3'd4:    code_c = blank_c[4] ? 4'hF : sel_digits_c[19:16];
      3'd5:    code_c = sel_neg_c ? 4'hA : 4'hF;
      default: code_c = 4'hF;
    endcase
    if (wrap_c) begin
      digit_en_d   = NPOS'(1) << idx_d;
      digit_code_d = code_c;
    end
  end

  // Datapath and scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      operand_q    <= '0;
      ch_q         <= 1'b0;
      last_q       <= 1'b1;
      x_digits_q   <= '0;
      y_digits_q   <= '0;
      done_pulse_q <= 1'b0;
      done_ch_q    <= 1'b0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      digit_en_q   <= NPOS'(1);
      digit_code_q <= 4'h0;
`ifdef SIGN_DISPLAY_EN
      sign_q       <= 1'b0;
      x_neg_q      <= 1'b0;
      y_neg_q      <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      operand_q    <= operand_d;
      ch_q         <= ch_d;
      last_q       <= last_d;
      x_digits_q   <= x_digits_d;
      y_digits_q   <= y_digits_d;
      done_pulse_q <= done_pulse_d;
      done_ch_q    <= done_ch_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      digit_en_q   <= digit_en_d;
      digit_code_q <= digit_code_d;
`ifdef SIGN_DISPLAY_EN
      sign_q       <= sign_d;
      x_neg_q      <= x_neg_d;
      y_neg_q      <= y_neg_d;
`endif
    end
  end

  assign x_digits   = x_digits_q;
  assign y_digits   = y_digits_q;
  assign done_pulse = done_pulse_q;
  assign done_ch    = done_ch_q;
  assign digit_en   = digit_en_q;
  assign digit_code = digit_code_q;
`ifdef SIGN_DISPLAY_EN
  assign x_neg      = x_neg_q;
  assign y_neg      = y_neg_q;
`endif

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed bench for bcd_display_scheduler: conversion latency and buffers,
// round-robin arbitration, scan/blanking sequence, reset abort, sign option.
module tb_bcd_display_scheduler;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned SDIV   = 4;
`ifdef SIGN_DISPLAY_EN
  localparam int unsigned NPOS = 6;
`else
  localparam int unsigned NPOS = 5;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            x_valid, y_valid, x_ready, y_ready;
  logic [15:0]     x_value, y_value;
  logic            disp_sel, busy, done_pulse, done_ch;
  logic [19:0]     x_digits, y_digits;
  logic [NPOS-1:0] digit_en;
  logic [3:0]      digit_code;
`ifdef SIGN_DISPLAY_EN
  logic            x_neg, y_neg;
  logic            exp_xn = 1'b0, exp_yn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_x = '0, exp_y = '0;

  typedef struct {
    logic        ch;
    logic [15:0] value;
    logic [19:0] exp;
    logic        neg;
  } vec_t;
  vec_t vecs[6];

  bcd_display_scheduler #(.SETTLE_CYCLES(SETTLE), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .rst(rst),
    .x_valid(x_valid), .x_value(x_value), .x_ready(x_ready),
    .y_valid(y_valid), .y_value(y_value), .y_ready(y_ready),
    .disp_sel(disp_sel), .busy(busy), .done_pulse(done_pulse), .done_ch(done_ch),
    .x_digits(x_digits), .y_digits(y_digits), .digit_code(digit_code),
`ifdef SIGN_DISPLAY_EN
    .digit_en(digit_en), .x_neg(x_neg), .y_neg(y_neg)
`else
    .digit_en(digit_en)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One request on channel ch; checks latency, busy and both buffers.
  task automatic do_req(input logic ch, input logic [15:0] v, input logic [19:0] exp, input logic neg);
    int n;
    logic [19:0] old;
    @(negedge clk);
    if (ch) begin y_valid = 1'b1; y_value = v; end
    else    begin x_valid = 1'b1; x_value = v; end
    #1;
    n = 0;
    while ((ch ? y_ready : x_ready) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("req_ready", 32'(ch ? y_ready : x_ready), 32'd1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    y_valid = 1'b0;
    old = ch ? exp_y : exp_x;
    if (ch) exp_y = exp; else exp_x = exp;
`ifdef SIGN_DISPLAY_EN
    if (ch) exp_yn = neg; else exp_xn = neg;
`endif
    for (int k = 1; k <= int'(SETTLE) + 3; k++) begin
      @(negedge clk);
      chk($sformatf("done_pulse_k%0d", k), 32'(done_pulse), 32'(k == int'(SETTLE) + 2));
      if (k <= int'(SETTLE) + 1) chk($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
      if (k == int'(SETTLE) + 1) chk("buf_before_done", 32'(ch ? y_digits : x_digits), 32'(old));
      if (k == int'(SETTLE) + 2) begin
        chk("busy_done", 32'(busy), 32'd0);
        chk("done_ch", 32'(done_ch), 32'(ch));
        chk("x_digits", 32'(x_digits), 32'(exp_x));
        chk("y_digits", 32'(y_digits), 32'(exp_y));
`ifdef SIGN_DISPLAY_EN
        chk("x_neg", 32'(x_neg), 32'(exp_xn));
        chk("y_neg", 32'(y_neg), 32'(exp_yn));
`endif
      end
    end
  endtask

  // Align to the scan wrap into position 0, then check each position for SDIV cycles.
  task automatic check_scan(input logic [23:0] codes, input string tag);
    int n;
    logic [NPOS-1:0] top, want;
    top = NPOS'(1) << (NPOS - 1);
    n = 0;
    @(negedge clk);
    while (digit_en !== top && n < 200) begin @(negedge clk); n++; end
    while (digit_en === top && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_align"}, 32'(n < 200), 32'd1);
    for (int p = 0; p < int'(NPOS); p++) begin
      want = NPOS'(1) << p;
      for (int c = 0; c < int'(SDIV); c++) begin
        if (c == 0 || c == int'(SDIV) - 1) begin
          chk($sformatf("%s_en_p%0d_c%0d", tag, p, c), 32'(digit_en), 32'(want));
          chk($sformatf("%s_code_p%0d_c%0d", tag, p, c), 32'(digit_code), 32'(codes[4*p +: 4]));
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; x_valid = 1'b0; y_valid = 1'b0;
    x_value = '0; y_value = '0; disp_sel = 1'b0;

    vecs[0] = '{ch: 1'b0, value: 16'd12345, exp: 20'h12345, neg: 1'b0};
`ifdef SIGN_DISPLAY_EN
    vecs[1] = '{ch: 1'b1, value: 16'hFFFF,  exp: 20'h00001, neg: 1'b1};
`else
    vecs[1] = '{ch: 1'b1, value: 16'hFFFF,  exp: 20'h65535, neg: 1'b0};
`endif
    vecs[2] = '{ch: 1'b1, value: 16'd0,     exp: 20'h00000, neg: 1'b0};
    vecs[3] = '{ch: 1'b0, value: 16'd999,   exp: 20'h00999, neg: 1'b0};
    vecs[4] = '{ch: 1'b1, value: 16'd10000, exp: 20'h10000, neg: 1'b0};
    vecs[5] = '{ch: 1'b0, value: 16'd42,    exp: 20'h00042, neg: 1'b0};

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_x_ready", 32'(x_ready), 32'd0);
    chk("rst_y_ready", 32'(y_ready), 32'd0);
    chk("rst_done_pulse", 32'(done_pulse), 32'd0);
    chk("rst_done_ch", 32'(done_ch), 32'd0);
    chk("rst_x_digits", 32'(x_digits), 32'd0);
    chk("rst_y_digits", 32'(y_digits), 32'd0);
    chk("rst_digit_en", 32'(digit_en), 32'd1);
    chk("rst_digit_code", 32'(digit_code), 32'd0);
    rst = 1'b0;

    // Table of single conversions.
    foreach (vecs[i]) do_req(vecs[i].ch, vecs[i].value, vecs[i].exp, vecs[i].neg);

    // Scan and blanking: X=42, then Y=10000, then X=0.
    disp_sel = 1'b0;
    check_scan(24'hFFFF42, "scan_x42");
    disp_sel = 1'b1;
    check_scan(24'hF10000, "scan_y10000");
    disp_sel = 1'b0;
    do_req(1'b0, 16'd0, 20'h00000, 1'b0);
    check_scan(24'hFFFFF0, "scan_x0");

    // Round-robin with both valids held after reset: X, Y, X, Y.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    x_value = 16'd1; y_value = 16'd2;
    x_valid = 1'b1; y_valid = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(x_ready || y_ready) && n < 20) begin @(negedge clk); #1; n++; end
      chk($sformatf("arb_grant%0d", g), 32'({x_ready, y_ready}), (g % 2 == 0) ? 32'd2 : 32'd1);
      if (g > 0) chk($sformatf("arb_gap%0d", g), 32'(n), 32'(SETTLE + 2));
      @(posedge clk); #1;
    end
    x_valid = 1'b0; y_valid = 1'b0;
    repeat (SETTLE + 3) @(negedge clk);
    chk("arb_x_digits", 32'(x_digits), 32'h00001);
    chk("arb_y_digits", 32'(y_digits), 32'h00002);
    exp_x = 20'h00001; exp_y = 20'h00002;

    // Reset during the settle window aborts the conversion.
    @(negedge clk);
    x_valid = 1'b1; x_value = 16'd999;
    #1;
    n = 0;
    while (x_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk("abort_ready", 32'(x_ready), 32'd1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_x = '0; exp_y = '0;
`ifdef SIGN_DISPLAY_EN
    exp_xn = 1'b0; exp_yn = 1'b0;
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort_done_k%0d", k), 32'(done_pulse), 32'd0);
      chk($sformatf("abort_busy_k%0d", k), 32'(busy), 32'd0);
    end
    chk("abort_x_digits", 32'(x_digits), 32'd0);
    chk("abort_y_digits", 32'(y_digits), 32'd0);
    do_req(1'b0, 16'd7, 20'h00007, 1'b0);

`ifdef SIGN_DISPLAY_EN
    // Signed display: -1 shows minus in position 5, -32768 magnitude.
    disp_sel = 1'b0;
    do_req(1'b0, 16'hFFFF, 20'h00001, 1'b1);
    check_scan(24'hAFFFF1, "scan_neg1");
    do_req(1'b0, 16'h8000, 20'h32768, 1'b1);
    do_req(1'b0, 16'd5, 20'h00005, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
